// File: rtl/axi_tag_pkg.sv
// axi_tag_pkg
// Shared types and helpers for the per-master AXI tagging stage.
//   wr_st_t   : write-channel ordering FSM states
//   OUT_CNT_W : width of the outstanding-transaction counters
//   tag_id    : builds the bus-side ID {index, native id}
package axi_tag_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } wr_st_t;

  localparam int OUT_CNT_W = 4;

  // The result is 32 bits wide; callers size-cast it to their tagged ID width.
  function automatic logic [31:0] tag_id(input int unsigned index,
                                         input logic [31:0] id,
                                         input int unsigned id_w);
    return (32'(index) << id_w) | id;
  endfunction

endpackage

// File: rtl/axi_inf.sv
// AXI_INF
// Minimal AXI bundle shared between a master, the tagger and the arbiter.
//   ID_W   : transaction ID width on this bundle
//   ADDR_W : address width
//   DATA_W : data width
// Modport M drives address/data/response-ready; modport S is the mirror.
interface AXI_INF #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     WR_ADDR_ID;
  logic [ADDR_W-1:0]   WR_ADDR;
  logic [7:0]          WR_ADDR_LEN;
  logic [2:0]          WR_ADDR_SIZE;
  logic [1:0]          WR_ADDR_BURST;
  logic                WR_ADDR_VALID;
  logic                WR_ADDR_READY;

  logic [DATA_W-1:0]   WR_DATA;
  logic [DATA_W/8-1:0] WR_DATA_STRB;
  logic                WR_DATA_LAST;
  logic                WR_DATA_VALID;
  logic                WR_DATA_READY;

  logic [ID_W-1:0]     WR_BACK_ID;
  logic [1:0]          WR_BACK_RESP;
  logic                WR_BACK_VALID;
  logic                WR_BACK_READY;

  logic [ID_W-1:0]     RD_ADDR_ID;
  logic [ADDR_W-1:0]   RD_ADDR;
  logic [7:0]          RD_ADDR_LEN;
  logic [2:0]          RD_ADDR_SIZE;
  logic [1:0]          RD_ADDR_BURST;
  logic                RD_ADDR_VALID;
  logic                RD_ADDR_READY;

  logic [ID_W-1:0]     RD_DATA_ID;
  logic [DATA_W-1:0]   RD_DATA;
  logic [1:0]          RD_DATA_RESP;
  logic                RD_DATA_LAST;
  logic                RD_DATA_VALID;
  logic                RD_DATA_READY;

  modport M (
    output WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_SIZE, WR_ADDR_BURST, WR_ADDR_VALID,
    input  WR_ADDR_READY,
    output WR_DATA, WR_DATA_STRB, WR_DATA_LAST, WR_DATA_VALID,
    input  WR_DATA_READY,
    input  WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
    output WR_BACK_READY,
    output RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_SIZE, RD_ADDR_BURST, RD_ADDR_VALID,
    input  RD_ADDR_READY,
    input  RD_DATA_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
    output RD_DATA_READY
  );

  modport S (
    input  WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_SIZE, WR_ADDR_BURST, WR_ADDR_VALID,
    output WR_ADDR_READY,
    input  WR_DATA, WR_DATA_STRB, WR_DATA_LAST, WR_DATA_VALID,
    output WR_DATA_READY,
    output WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
    input  WR_BACK_READY,
    input  RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_SIZE, RD_ADDR_BURST, RD_ADDR_VALID,
    output RD_ADDR_READY,
    output RD_DATA_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
    input  RD_DATA_READY
  );

endinterface

// File: rtl/axi_outstanding_counter.sv
// axi_outstanding_counter
// Saturating-at-zero up/down counter of outstanding transactions.
//   clk, rstn : clock, synchronous active-low reset
//   inc, dec  : one transaction accepted / one transaction retired
//   cnt       : current count (registered)
//   full      : cnt has reached MAX (registered state only)
//   underflow : a retire arrived with nothing outstanding (combinational pulse)
module axi_outstanding_counter
  import axi_tag_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 inc,
  input  logic                 dec,
  output logic [OUT_CNT_W-1:0] cnt,
  output logic                 full,
  output logic                 underflow
);

  logic [OUT_CNT_W-1:0] cnt_q;
  logic [OUT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc, dec})
      2'b10:   cnt_d = cnt_q + OUT_CNT_W'(1);
      2'b01:   cnt_d = (cnt_q == '0) ? '0 : cnt_q - OUT_CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt       = cnt_q;
  assign full      = (cnt_q >= OUT_CNT_W'(MAX));
  assign underflow = dec & ~inc & (cnt_q == '0);

endmodule

// File: rtl/axi_master_tagger.sv
// axi_master_tagger
// Per-master front end: tags AW/AR IDs with MASTER_INDEX, strips the tag from
// B/R, keeps write data behind its address, and caps outstanding bursts.
//   clk, rstn      : clock, synchronous active-low reset
//   AXI_MASTER     : master side, native M_ID-bit IDs
//   AXI_BUS        : arbiter side, (M_ID+M_WIDTH)-bit tagged IDs
//   wr_outstanding : accepted-but-unresponded write bursts
//   rd_outstanding : accepted-but-incomplete read bursts
//   id_err         : sticky, a response carried another master's index
//   cnt_err        : sticky, a response arrived with its counter at zero
module axi_master_tagger
  import axi_tag_pkg::*;
#(
  parameter int M_ID         = 2,
  parameter int M_WIDTH      = 2,
  parameter int MASTER_INDEX = 0,
  parameter int MAX_WR_OUT   = 4,
  parameter int MAX_RD_OUT   = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  AXI_INF.S                    AXI_MASTER,
  AXI_INF.M                    AXI_BUS,
  output logic [OUT_CNT_W-1:0] wr_outstanding,
  output logic [OUT_CNT_W-1:0] rd_outstanding,
  output logic                 id_err,
  output logic                 cnt_err
);

  localparam int TAG_W = M_ID + M_WIDTH;
  localparam logic [M_WIDTH-1:0] IDX = M_WIDTH'(MASTER_INDEX);

  wr_st_t wr_st_q, wr_st_d;
  logic   id_err_q, id_err_d;
  logic   cnt_err_q, cnt_err_d;

  logic [OUT_CNT_W-1:0] wr_cnt, rd_cnt;
  logic wr_full, rd_full, wr_uf, rd_uf;
  logic aw_open, w_open, ar_open;
  logic aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs, foreign;

  // Gates use only registered state and rstn so no valid->ready path exists.
  assign aw_open = rstn & (wr_st_q == W_IDLE) & ~wr_full;
  assign w_open  = rstn & (wr_st_q == W_DATA);
  assign ar_open = rstn & ~rd_full;

  // Write address
  assign AXI_BUS.WR_ADDR_ID    = TAG_W'(tag_id(MASTER_INDEX, 32'(AXI_MASTER.WR_ADDR_ID), M_ID));
  assign AXI_BUS.WR_ADDR       = AXI_MASTER.WR_ADDR;
  assign AXI_BUS.WR_ADDR_LEN   = AXI_MASTER.WR_ADDR_LEN;
  assign AXI_BUS.WR_ADDR_SIZE  = AXI_MASTER.WR_ADDR_SIZE;
  assign AXI_BUS.WR_ADDR_BURST = AXI_MASTER.WR_ADDR_BURST;
  assign AXI_BUS.WR_ADDR_VALID = AXI_MASTER.WR_ADDR_VALID & aw_open;
  assign AXI_MASTER.WR_ADDR_READY = AXI_BUS.WR_ADDR_READY & aw_open;

  // Write data
  assign AXI_BUS.WR_DATA       = AXI_MASTER.WR_DATA;
  assign AXI_BUS.WR_DATA_STRB  = AXI_MASTER.WR_DATA_STRB;
  assign AXI_BUS.WR_DATA_LAST  = AXI_MASTER.WR_DATA_LAST;
  assign AXI_BUS.WR_DATA_VALID = AXI_MASTER.WR_DATA_VALID & w_open;
  assign AXI_MASTER.WR_DATA_READY = AXI_BUS.WR_DATA_READY & w_open;

  // Write response
  assign AXI_MASTER.WR_BACK_ID    = AXI_BUS.WR_BACK_ID[M_ID-1:0];
  assign AXI_MASTER.WR_BACK_RESP  = AXI_BUS.WR_BACK_RESP;
  assign AXI_MASTER.WR_BACK_VALID = AXI_BUS.WR_BACK_VALID & rstn;
  assign AXI_BUS.WR_BACK_READY    = AXI_MASTER.WR_BACK_READY & rstn;

  // Read address
  assign AXI_BUS.RD_ADDR_ID    = TAG_W'(tag_id(MASTER_INDEX, 32'(AXI_MASTER.RD_ADDR_ID), M_ID));
  assign AXI_BUS.RD_ADDR       = AXI_MASTER.RD_ADDR;
  assign AXI_BUS.RD_ADDR_LEN   = AXI_MASTER.RD_ADDR_LEN;
  assign AXI_BUS.RD_ADDR_SIZE  = AXI_MASTER.RD_ADDR_SIZE;
  assign AXI_BUS.RD_ADDR_BURST = AXI_MASTER.RD_ADDR_BURST;
  assign AXI_BUS.RD_ADDR_VALID = AXI_MASTER.RD_ADDR_VALID & ar_open;
  assign AXI_MASTER.RD_ADDR_READY = AXI_BUS.RD_ADDR_READY & ar_open;

  // Read data
  assign AXI_MASTER.RD_DATA_ID    = AXI_BUS.RD_DATA_ID[M_ID-1:0];
  assign AXI_MASTER.RD_DATA       = AXI_BUS.RD_DATA;
  assign AXI_MASTER.RD_DATA_RESP  = AXI_BUS.RD_DATA_RESP;
  assign AXI_MASTER.RD_DATA_LAST  = AXI_BUS.RD_DATA_LAST;
  assign AXI_MASTER.RD_DATA_VALID = AXI_BUS.RD_DATA_VALID & rstn;
  assign AXI_BUS.RD_DATA_READY    = AXI_MASTER.RD_DATA_READY & rstn;

  assign aw_hs     = AXI_MASTER.WR_ADDR_VALID & AXI_BUS.WR_ADDR_READY & aw_open;
  assign w_last_hs = AXI_MASTER.WR_DATA_VALID & AXI_BUS.WR_DATA_READY & w_open
                     & AXI_MASTER.WR_DATA_LAST;
  assign b_hs      = AXI_BUS.WR_BACK_VALID & AXI_MASTER.WR_BACK_READY & rstn;
  assign ar_hs     = AXI_MASTER.RD_ADDR_VALID & AXI_BUS.RD_ADDR_READY & ar_open;
  assign r_last_hs = AXI_BUS.RD_DATA_VALID & AXI_MASTER.RD_DATA_READY & rstn
                     & AXI_BUS.RD_DATA_LAST;

  // Any visible response with another index is flagged; it is still forwarded.
  assign foreign = (AXI_BUS.WR_BACK_VALID & (AXI_BUS.WR_BACK_ID[M_ID+:M_WIDTH] != IDX))
                 | (AXI_BUS.RD_DATA_VALID & (AXI_BUS.RD_DATA_ID[M_ID+:M_WIDTH] != IDX));

  axi_outstanding_counter #(.MAX(MAX_WR_OUT)) u_wr_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .inc       (aw_hs),
    .dec       (b_hs),
    .cnt       (wr_cnt),
    .full      (wr_full),
    .underflow (wr_uf)
  );

  axi_outstanding_counter #(.MAX(MAX_RD_OUT)) u_rd_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .inc       (ar_hs),
    .dec       (r_last_hs),
    .cnt       (rd_cnt),
    .full      (rd_full),
    .underflow (rd_uf)
  );

  always_comb begin
    wr_st_d = wr_st_q;
    unique case (wr_st_q)
      W_IDLE:  if (aw_hs)     wr_st_d = W_DATA;
      W_DATA:  if (w_last_hs) wr_st_d = W_IDLE;
      default: wr_st_d = W_IDLE;
    endcase
    id_err_d  = id_err_q | foreign;
    cnt_err_d = cnt_err_q | wr_uf | rd_uf;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_st_q   <= W_IDLE;
      id_err_q  <= 1'b0;
      cnt_err_q <= 1'b0;
    end else begin
      wr_st_q   <= wr_st_d;
      id_err_q  <= id_err_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign wr_outstanding = rstn ? wr_cnt : '0;
  assign rd_outstanding = rstn ? rd_cnt : '0;
  assign id_err         = id_err_q;
  assign cnt_err        = cnt_err_q;

endmodule

// File: tb/tb_axi_master_tagger.sv
module tb_axi_master_tagger;

  logic clk = 1'b0;
  logic rstn;
  logic [3:0] wr_outstanding, rd_outstanding;
  logic id_err, cnt_err;

  int n_vec  = 0;
  int n_miss = 0;

  logic [63:0] aw_q[$];
  logic [63:0] w_q[$];
  logic [63:0] ar_q[$];

  AXI_INF #(.ID_W(2)) m_if ();
  AXI_INF #(.ID_W(4)) b_if ();

  axi_master_tagger #(
    .M_ID         (2),
    .M_WIDTH      (2),
    .MASTER_INDEX (2),
    .MAX_WR_OUT   (4),
    .MAX_RD_OUT   (2)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .AXI_MASTER     (m_if),
    .AXI_BUS        (b_if),
    .wr_outstanding (wr_outstanding),
    .rd_outstanding (rd_outstanding),
    .id_err         (id_err),
    .cnt_err        (cnt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Scoreboard: every bus-side address/data handshake must match the next
  // expected item pushed when the stimulus was driven.
  always @(negedge clk) begin
    logic [63:0] e;
    if (b_if.WR_ADDR_VALID === 1'b1 && b_if.WR_ADDR_READY === 1'b1) begin
      if (aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
      else begin
        e = aw_q.pop_front();
        check("aw_tag_addr", {28'd0, b_if.WR_ADDR_ID, b_if.WR_ADDR}, e);
      end
    end
    if (b_if.WR_DATA_VALID === 1'b1 && b_if.WR_DATA_READY === 1'b1) begin
      if (w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
      else begin
        e = w_q.pop_front();
        check("w_data_last", {31'd0, b_if.WR_DATA_LAST, b_if.WR_DATA}, e);
      end
    end
    if (b_if.RD_ADDR_VALID === 1'b1 && b_if.RD_ADDR_READY === 1'b1) begin
      if (ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
      else begin
        e = ar_q.pop_front();
        check("ar_tag_addr", {28'd0, b_if.RD_ADDR_ID, b_if.RD_ADDR}, e);
      end
    end
  end

  initial begin
    rstn = 1'b0;
    m_if.WR_ADDR_ID = '0; m_if.WR_ADDR = '0; m_if.WR_ADDR_LEN = '0;
    m_if.WR_ADDR_SIZE = 3'd2; m_if.WR_ADDR_BURST = 2'd1; m_if.WR_ADDR_VALID = 1'b1;
    m_if.WR_DATA = '0; m_if.WR_DATA_STRB = 4'hF; m_if.WR_DATA_LAST = 1'b0;
    m_if.WR_DATA_VALID = 1'b1; m_if.WR_BACK_READY = 1'b1;
    m_if.RD_ADDR_ID = '0; m_if.RD_ADDR = '0; m_if.RD_ADDR_LEN = '0;
    m_if.RD_ADDR_SIZE = 3'd2; m_if.RD_ADDR_BURST = 2'd1; m_if.RD_ADDR_VALID = 1'b1;
    m_if.RD_DATA_READY = 1'b1;
    b_if.WR_ADDR_READY = 1'b1; b_if.WR_DATA_READY = 1'b1; b_if.RD_ADDR_READY = 1'b1;
    b_if.WR_BACK_ID = '0; b_if.WR_BACK_RESP = '0; b_if.WR_BACK_VALID = 1'b1;
    b_if.RD_DATA_ID = '0; b_if.RD_DATA = '0; b_if.RD_DATA_RESP = '0;
    b_if.RD_DATA_LAST = 1'b0; b_if.RD_DATA_VALID = 1'b1;

    // Reset: everything gated even with valids asserted on both sides.
    step(); neg();
    check("rst_bus_aw_valid", b_if.WR_ADDR_VALID, 0);
    check("rst_bus_w_valid",  b_if.WR_DATA_VALID, 0);
    check("rst_bus_ar_valid", b_if.RD_ADDR_VALID, 0);
    check("rst_m_aw_ready",   m_if.WR_ADDR_READY, 0);
    check("rst_m_b_valid",    m_if.WR_BACK_VALID, 0);
    check("rst_flags",        {id_err, cnt_err, wr_outstanding, rd_outstanding}, 0);
    step();
    m_if.WR_ADDR_VALID = 1'b0; m_if.WR_DATA_VALID = 1'b0; m_if.RD_ADDR_VALID = 1'b0;
    b_if.WR_BACK_VALID = 1'b0; b_if.RD_DATA_VALID = 1'b0;
    rstn = 1'b1;
    step();

    // Single write with tag 2, native ID 1.
    m_if.WR_ADDR_VALID = 1'b1; m_if.WR_ADDR_ID = 2'd1; m_if.WR_ADDR = 32'h100;
    aw_q.push_back({28'd0, 4'b1001, 32'h100});
    neg();
    check("sw_bus_aw_id",  b_if.WR_ADDR_ID, 4'b1001);
    check("sw_m_aw_ready", m_if.WR_ADDR_READY, 1);
    check("sw_wr_out0",    wr_outstanding, 0);
    step();
    m_if.WR_ADDR_VALID = 1'b0;
    m_if.WR_DATA_VALID = 1'b1; m_if.WR_DATA = 32'hA5A5_0001; m_if.WR_DATA_LAST = 1'b1;
    w_q.push_back({31'd0, 1'b1, 32'hA5A5_0001});
    neg();
    check("sw_wr_out1",   wr_outstanding, 1);
    check("sw_bus_w_val", b_if.WR_DATA_VALID, 1);
    step();
    m_if.WR_DATA_VALID = 1'b0;
    b_if.WR_BACK_VALID = 1'b1; b_if.WR_BACK_ID = 4'b1001; b_if.WR_BACK_RESP = 2'd0;
    neg();
    check("sw_m_b_id",     m_if.WR_BACK_ID, 1);
    check("sw_m_b_valid",  m_if.WR_BACK_VALID, 1);
    check("sw_bus_b_rdy",  b_if.WR_BACK_READY, 1);
    step();
    b_if.WR_BACK_VALID = 1'b0;
    neg();
    check("sw_wr_out_back0", wr_outstanding, 0);

    // Early W: data held off until the address has gone.
    step();
    m_if.WR_DATA_VALID = 1'b1; m_if.WR_DATA = 32'h0000_1234; m_if.WR_DATA_LAST = 1'b0;
    neg();
    check("ew_bus_w_valid_a", b_if.WR_DATA_VALID, 0);
    check("ew_m_w_ready_a",   m_if.WR_DATA_READY, 0);
    step(); neg();
    check("ew_bus_w_valid_b", b_if.WR_DATA_VALID, 0);
    step();
    m_if.WR_ADDR_VALID = 1'b1; m_if.WR_ADDR_ID = 2'd3; m_if.WR_ADDR = 32'h200;
    aw_q.push_back({28'd0, 4'b1011, 32'h200});
    neg();
    check("ew_w_blocked_aw_cycle", {b_if.WR_DATA_VALID, m_if.WR_DATA_READY}, 0);
    step();
    w_q.push_back({31'd0, 1'b0, 32'h0000_1234});
    neg();
    check("ew_w_open", {b_if.WR_DATA_VALID, m_if.WR_DATA_READY}, 2'b11);
    check("ew_aw_held", {b_if.WR_ADDR_VALID, m_if.WR_ADDR_READY}, 0);
    step();
    m_if.WR_DATA = 32'h0000_5678; m_if.WR_DATA_LAST = 1'b1;
    w_q.push_back({31'd0, 1'b1, 32'h0000_5678});
    step();
    m_if.WR_ADDR_VALID = 1'b0; m_if.WR_DATA_VALID = 1'b0;

    // Simultaneous AW and B with one outstanding.
    m_if.WR_ADDR_VALID = 1'b1; m_if.WR_ADDR_ID = 2'd2; m_if.WR_ADDR = 32'h300;
    aw_q.push_back({28'd0, 4'b1010, 32'h300});
    b_if.WR_BACK_VALID = 1'b1; b_if.WR_BACK_ID = 4'b1011;
    neg();
    check("sim_wr_out_before", wr_outstanding, 1);
    check("sim_m_b_id", m_if.WR_BACK_ID, 3);
    step();
    m_if.WR_ADDR_VALID = 1'b0; b_if.WR_BACK_VALID = 1'b0;
    neg();
    check("sim_wr_out_after", wr_outstanding, 1);
    step();
    m_if.WR_DATA_VALID = 1'b1; m_if.WR_DATA = 32'h9; m_if.WR_DATA_LAST = 1'b1;
    w_q.push_back({31'd0, 1'b1, 32'h9});
    step();
    m_if.WR_DATA_VALID = 1'b0;
    b_if.WR_BACK_VALID = 1'b1; b_if.WR_BACK_ID = 4'b1010;
    step();
    b_if.WR_BACK_VALID = 1'b0;
    neg();
    check("sim_wr_out_drained", wr_outstanding, 0);

    // Underflow on B with nothing outstanding.
    step();
    b_if.WR_BACK_VALID = 1'b1; b_if.WR_BACK_ID = 4'b1000;
    neg();
    check("uf_cnt_err_before", cnt_err, 0);
    step();
    b_if.WR_BACK_VALID = 1'b0;
    neg();
    check("uf_cnt_err_after", cnt_err, 1);
    check("uf_wr_out_zero", wr_outstanding, 0);

    // Read limit of 2: third AR stalls until a read burst completes.
    step();
    m_if.RD_ADDR_VALID = 1'b1; m_if.RD_ADDR_ID = 2'd0; m_if.RD_ADDR = 32'h1000;
    ar_q.push_back({28'd0, 4'b1000, 32'h1000});
    neg();
    check("rl_ar_ready_0", m_if.RD_ADDR_READY, 1);
    step();
    m_if.RD_ADDR_ID = 2'd1; m_if.RD_ADDR = 32'h1100;
    ar_q.push_back({28'd0, 4'b1001, 32'h1100});
    step();
    m_if.RD_ADDR_ID = 2'd2; m_if.RD_ADDR = 32'h1200;
    neg();
    check("rl_ar_stall", {m_if.RD_ADDR_READY, b_if.RD_ADDR_VALID}, 0);
    check("rl_rd_out_full", rd_outstanding, 2);
    step(); neg();
    check("rl_ar_still_stalled", m_if.RD_ADDR_READY, 0);
    step();
    b_if.RD_DATA_VALID = 1'b1; b_if.RD_DATA_ID = 4'b1000; b_if.RD_DATA = 32'hDD;
    b_if.RD_DATA_LAST = 1'b1;
    neg();
    check("rl_r_fwd", {m_if.RD_DATA_VALID, m_if.RD_DATA_LAST, m_if.RD_DATA_ID, m_if.RD_DATA},
          {1'b1, 1'b1, 2'd0, 32'hDD});
    check("rl_ar_stall_r_cycle", m_if.RD_ADDR_READY, 0);
    step();
    b_if.RD_DATA_VALID = 1'b0;
    ar_q.push_back({28'd0, 4'b1010, 32'h1200});
    neg();
    check("rl_ar_reopen", m_if.RD_ADDR_READY, 1);
    check("rl_rd_out_freed", rd_outstanding, 1);
    step();
    m_if.RD_ADDR_VALID = 1'b0;
    b_if.RD_DATA_VALID = 1'b1; b_if.RD_DATA_ID = 4'b1001; b_if.RD_DATA_LAST = 1'b0;
    neg();
    check("rl_rd_out_refull", rd_outstanding, 2);
    step();
    b_if.RD_DATA_LAST = 1'b1;
    neg();
    check("rl_nonlast_no_dec", rd_outstanding, 2);
    step();
    b_if.RD_DATA_VALID = 1'b0;
    neg();
    check("rl_rd_out_last_dec", rd_outstanding, 1);

    // Foreign index on R: forwarded, flagged from the next cycle.
    step();
    b_if.RD_DATA_VALID = 1'b1; b_if.RD_DATA_ID = 4'b1101; b_if.RD_DATA_LAST = 1'b0;
    neg();
    check("fr_id_err_before", id_err, 0);
    check("fr_forwarded", {m_if.RD_DATA_VALID, m_if.RD_DATA_ID}, {1'b1, 2'd1});
    step();
    b_if.RD_DATA_VALID = 1'b0;
    neg();
    check("fr_id_err_after", id_err, 1);
    check("fr_rd_out_kept", rd_outstanding, 1);

    // Reset in the middle of a write burst.
    step();
    m_if.WR_ADDR_VALID = 1'b1; m_if.WR_ADDR_ID = 2'd0; m_if.WR_ADDR = 32'h400;
    aw_q.push_back({28'd0, 4'b1000, 32'h400});
    step();
    m_if.WR_ADDR_VALID = 1'b0;
    m_if.WR_DATA_VALID = 1'b1; m_if.WR_DATA = 32'hAA; m_if.WR_DATA_LAST = 1'b0;
    w_q.push_back({31'd0, 1'b0, 32'hAA});
    step();
    rstn = 1'b0;
    m_if.WR_DATA = 32'hBB; m_if.WR_ADDR_VALID = 1'b1;
    neg();
    check("mr_outputs_in_reset",
          {b_if.WR_DATA_VALID, b_if.WR_ADDR_VALID, m_if.WR_DATA_READY, wr_outstanding}, 0);
    step();
    rstn = 1'b1; m_if.WR_ADDR_VALID = 1'b0;
    neg();
    check("mr_fsm_idle_w_blocked", b_if.WR_DATA_VALID, 0);
    check("mr_counters", {wr_outstanding, rd_outstanding}, 0);
    check("mr_flags", {id_err, cnt_err}, 0);
    step();
    m_if.WR_ADDR_VALID = 1'b1; m_if.WR_ADDR_ID = 2'd1; m_if.WR_ADDR = 32'h500;
    aw_q.push_back({28'd0, 4'b1001, 32'h500});
    neg();
    check("mr_aw_accepted", b_if.WR_ADDR_VALID, 1);
    step();
    m_if.WR_ADDR_VALID = 1'b0; m_if.WR_DATA_VALID = 1'b0;
    step();
    check("sb_drained", {32'(aw_q.size()), 16'(w_q.size()), 16'(ar_q.size())}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
